// File: rtl/jtframe_inputs.sv
// jtframe_inputs: player-input front end.
// Merges the PS/2 keyboard event stream with up to four hps_io joysticks and
// produces registered, active-low game inputs with coin-pulse shaping,
// per-button autofire and a pause toggle.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   ps2_key      [10] event toggle, [9] pressed, [7:0] scan code
//   joy_flat     16 bits per player, active high
//   autofire_en  per-button autofire enable, shared by all players
//   joystick     (4+BUTTONS) bits per player, active low
//   start_button per-player start, active low
//   coin_input   per-player shaped coin pulse, active low
//   service      service key, active low
//   dip_pause    1 = running, 0 = paused
module jtframe_inputs #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 2,
  parameter int COIN_W       = 4800000,
  parameter int AUTOFIRE_DIV = 1600000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [10:0]                    ps2_key,
  input  logic [16*PLAYERS-1:0]          joy_flat,
  input  logic [BUTTONS-1:0]             autofire_en,
  output logic [(4+BUTTONS)*PLAYERS-1:0] joystick,
  output logic [PLAYERS-1:0]             start_button,
  output logic [PLAYERS-1:0]             coin_input,
  output logic                           service,
  output logic                           dip_pause
);

  localparam int JW = 4 + BUTTONS;                    // directions + buttons
  localparam int KP = (PLAYERS < 2) ? PLAYERS : 2;    // players with keys
  localparam logic [22:0] AF_LAST   = 23'(AUTOFIRE_DIV - 1);
  localparam logic [22:0] COIN_LAST = 23'(COIN_W - 1);

  typedef enum logic {COIN_IDLE, COIN_PULSE} coin_state_e;

  // One-hot select of a joystick-layout bit; bits beyond this build's width
  // simply vanish, which is how out-of-range buttons get no key flop.
  function automatic logic [JW-1:0] map_bit(input int idx);
    map_bit = '0;
    for (int i = 0; i < JW; i++) if (i == idx) map_bit[i] = 1'b1;
  endfunction

  // ---------------------------------------------------------------- keyboard
  logic          ps2_tog;
  logic          key_event;
  logic [JW-1:0] sel_joy [KP];
  logic [KP-1:0] sel_start;
  logic          sel_coin, sel_pause, sel_service;

  assign key_event = ps2_key[10] ^ ps2_tog;

  // NOTE: every output of a combinational block gets a default first, so no
  // code path leaves a value held and a latch is never inferred.
  always_comb begin
    for (int p = 0; p < KP; p++) sel_joy[p] = '0;
    sel_start   = '0;
    sel_coin    = 1'b0;
    sel_pause   = 1'b0;
    sel_service = 1'b0;
    case (ps2_key[7:0])
      8'h74:        sel_joy[0] = map_bit(0);
      8'h6B:        sel_joy[0] = map_bit(1);
      8'h72:        sel_joy[0] = map_bit(2);
      8'h75:        sel_joy[0] = map_bit(3);
      8'h14, 8'h11: sel_joy[0] = map_bit(4);
      8'h29:        sel_joy[0] = map_bit(5);
      8'h12:        sel_joy[0] = map_bit(6);
      // P2 codes land on index KP-1, which only differs from P1 when KP == 2
      8'h34: if (KP > 1) sel_joy[KP-1] = map_bit(0);
      8'h23: if (KP > 1) sel_joy[KP-1] = map_bit(1);
      8'h2B: if (KP > 1) sel_joy[KP-1] = map_bit(2);
      8'h2D: if (KP > 1) sel_joy[KP-1] = map_bit(3);
      8'h1C: if (KP > 1) sel_joy[KP-1] = map_bit(4);
      8'h1B: if (KP > 1) sel_joy[KP-1] = map_bit(5);
      8'h15: if (KP > 1) sel_joy[KP-1] = map_bit(6);
      8'h05: sel_start[0] = 1'b1;
      8'h06: if (KP > 1) sel_start[KP-1] = 1'b1;
      8'h04: sel_coin    = 1'b1;
      8'h0C: sel_pause   = 1'b1;
      8'h03: sel_service = 1'b1;
      default: ;
    endcase
  end

  logic [JW-1:0] key_joy [KP];
  logic [KP-1:0] key_start;
  logic          key_coin, key_pause, key_service;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  // The key-state array is a handful of flops, so it is cleared on reset like
  // any other register rather than treated as uninitialised storage.
  always_ff @(posedge clk) begin
    ps2_tog <= ps2_key[10];   // on reset too: no event on the first cycle
    if (rst) begin
      for (int p = 0; p < KP; p++) key_joy[p] <= '0;
      key_start   <= '0;
      key_coin    <= 1'b0;
      key_pause   <= 1'b0;
      key_service <= 1'b0;
    end else if (key_event) begin
      for (int p = 0; p < KP; p++)
        key_joy[p] <= ps2_key[9] ? (key_joy[p] | sel_joy[p]) : (key_joy[p] & ~sel_joy[p]);
      key_start <= ps2_key[9] ? (key_start | sel_start) : (key_start & ~sel_start);
      if (sel_coin)    key_coin    <= ps2_key[9];
      if (sel_pause)   key_pause   <= ps2_key[9];
      if (sel_service) key_service <= ps2_key[9];
    end
  end

  // --------------------------------------------------------------- raw merge
  logic [JW-1:0] raw_joy [PLAYERS];
  logic          raw_start [PLAYERS];
  logic          raw_coin  [PLAYERS];
  logic          joy_pause [PLAYERS];
  logic          coin_busy [PLAYERS];

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    if (p < KP) begin : g_keys
      assign raw_joy[p]   = joy_flat[16*p +: JW] | key_joy[p];
      assign raw_start[p] = joy_flat[16*p+JW] | key_start[p];
    end else begin : g_nokeys
      assign raw_joy[p]   = joy_flat[16*p +: JW];
      assign raw_start[p] = joy_flat[16*p+JW];
    end
    if (p == 0) begin : g_coin_key
      assign raw_coin[p] = joy_flat[16*p+JW+1] | key_coin;
    end else begin : g_coin_joy
      assign raw_coin[p] = joy_flat[16*p+JW+1];
    end
    assign joy_pause[p] = joy_flat[16*p+JW+2];

    // Coin shaping: the pulse lasts COIN_W cycles, or until release if the
    // coin is still held when the count runs out. No retrigger while busy.
    coin_state_e st, st_nx;
    logic [22:0] cnt, cnt_nx;
    logic        coin_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        st     <= COIN_IDLE;
        cnt    <= '0;
        coin_r <= 1'b0;
      end else begin
        st     <= st_nx;
        cnt    <= cnt_nx;
        coin_r <= raw_coin[p];
      end
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      case (st)
        COIN_IDLE:
          if (raw_coin[p] && !coin_r) begin
            st_nx  = COIN_PULSE;
            cnt_nx = COIN_LAST;
          end
        COIN_PULSE:
          if (cnt != '0)        cnt_nx = cnt - 23'd1;
          else if (!raw_coin[p]) st_nx  = COIN_IDLE;
        default: st_nx = COIN_IDLE;
      endcase
    end

    assign coin_busy[p] = (st == COIN_PULSE);
  end

  // ---------------------------------------------------------------- autofire
  logic [22:0]        af_cnt;
  logic               af_phase;
  logic [BUTTONS-1:0] fire_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + 23'd1;
    end
  end

  // A button passes while the phase is high, or always when autofire is off.
  assign fire_ok = {BUTTONS{af_phase}} | ~autofire_en;

  logic [JW*PLAYERS-1:0] joy_next;
  always_comb begin
    joy_next = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_next[JW*p +: 4]         = ~raw_joy[p][3:0];
      joy_next[JW*p+4 +: BUTTONS] = ~(raw_joy[p][JW-1:4] & fire_ok);
    end
  end

  // ------------------------------------------------------------------- pause
  logic raw_pause, pause_r, paused;
  always_comb begin
    raw_pause = key_pause;
    for (int p = 0; p < PLAYERS; p++) raw_pause = raw_pause | joy_pause[p];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_r <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_r <= raw_pause;
      if (raw_pause && !pause_r) paused <= ~paused;
    end
  end

  // --------------------------------------------------------- output register
  always_ff @(posedge clk) begin
    if (rst) begin
      joystick     <= '1;
      start_button <= '1;
      coin_input   <= '1;
      service      <= 1'b1;
      dip_pause    <= 1'b1;
    end else begin
      joystick <= joy_next;
      for (int p = 0; p < PLAYERS; p++) begin
        start_button[p] <= ~raw_start[p];
        coin_input[p]   <= ~coin_busy[p];
      end
      service   <= ~key_service;
      dip_pause <= ~paused;
    end
  end

  // Extended-key flag and joystick bits above pause carry no function here.
  logic unused_inputs;
  always_comb begin
    unused_inputs = ps2_key[8];
    for (int p = 0; p < PLAYERS; p++)
      for (int b = JW + 3; b < 16; b++)
        unused_inputs = unused_inputs ^ joy_flat[16*p+b];
  end

endmodule

// File: tb/tb_jtframe_inputs.sv
// Testbench for jtframe_inputs. Two instances: A (2 players, 3 buttons,
// COIN_W 8, AUTOFIRE_DIV 4) and B (1 player, 1 button, COIN_W 1,
// AUTOFIRE_DIV 3). A behavioural model predicts every output after every
// clock edge from key-function state, elapsed cycles and pulse deadlines.
module tb_jtframe_inputs;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        rst;
  logic [10:0] ps2_in [2];
  logic [63:0] joy_in [2];
  logic [5:0]  en_in  [2];

  logic [13:0] joy_a;
  logic [1:0]  start_a, coin_a;
  logic        serv_a, pause_a;
  logic [4:0]  joy_b;
  logic [0:0]  start_b, coin_b;
  logic        serv_b, pause_b;

  jtframe_inputs #(.PLAYERS(2), .BUTTONS(3), .COIN_W(8), .AUTOFIRE_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .ps2_key(ps2_in[0]), .joy_flat(joy_in[0][31:0]),
    .autofire_en(en_in[0][2:0]), .joystick(joy_a), .start_button(start_a),
    .coin_input(coin_a), .service(serv_a), .dip_pause(pause_a));

  jtframe_inputs #(.PLAYERS(1), .BUTTONS(1), .COIN_W(1), .AUTOFIRE_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .ps2_key(ps2_in[1]), .joy_flat(joy_in[1][15:0]),
    .autofire_en(en_in[1][0:0]), .joystick(joy_b), .start_button(start_b),
    .coin_input(coin_b), .service(serv_b), .dip_pause(pause_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pl(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int bt(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int cw(input int d); return (d == 0) ? 8 : 1; endfunction
  function automatic int ad(input int d); return (d == 0) ? 4 : 3; endfunction

  // Key functions: 0-3 P1 dirs, 4-6 P1 buttons, 8-11 P2 dirs, 12-14 P2
  // buttons, 16/17 start P1/P2, 18 coin, 19 pause, 20 service.
  function automatic int key_fid(input logic [7:0] code);
    case (code)
      8'h74: return 0;  8'h6B: return 1;  8'h72: return 2;  8'h75: return 3;
      8'h14, 8'h11: return 4;  8'h29: return 5;  8'h12: return 6;
      8'h34: return 8;  8'h23: return 9;  8'h2B: return 10; 8'h2D: return 11;
      8'h1C: return 12; 8'h1B: return 13; 8'h15: return 14;
      8'h05: return 16; 8'h06: return 17; 8'h04: return 18;
      8'h0C: return 19; 8'h03: return 20;
      default: return -1;
    endcase
  endfunction

  // model state
  logic [20:0] kf [2];
  logic        tog [2];
  int          t [2];
  logic [3:0]  in_pulse [2];
  int          pstart [2][4];
  logic [3:0]  cprev [2];
  logic        paused [2];
  logic        pprev [2];
  // expectations for the edge about to happen
  logic [31:0] exp_joy [2];
  logic [3:0]  exp_start [2], exp_coin [2];
  logic        exp_serv [2], exp_pause [2];

  task automatic model_edge(input int d);
    int np, jw, tn, fid;
    logic r, ph, praw;
    logic [20:0] k;
    np = pl(d);
    jw = 4 + bt(d);
    k  = kf[d];
    tn = t[d] + 1;
    ph = ((t[d] / ad(d)) % 2) == 1;
    praw = k[19];
    exp_joy[d] = '0; exp_start[d] = '0; exp_coin[d] = '0;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < jw; i++) begin
        r = joy_in[d][16*p+i] | ((p < 2 && i < 7) ? k[8*p+i] : 1'b0);
        if (i < 4) exp_joy[d][jw*p+i] = rst | ~r;
        else       exp_joy[d][jw*p+i] = rst | ~(r & (ph | ~en_in[d][i-4]));
      end
      r = joy_in[d][16*p+jw] | ((p < 2) ? k[16+p] : 1'b0);
      exp_start[d][p] = rst | ~r;
      r = joy_in[d][16*p+jw+1] | ((p == 0) ? k[18] : 1'b0);
      exp_coin[d][p] = rst | ~in_pulse[d][p];
      if (!rst) begin
        if (in_pulse[d][p]) begin
          if ((tn - pstart[d][p]) >= cw(d) && !r) in_pulse[d][p] = 1'b0;
        end else if (r && !cprev[d][p]) begin
          in_pulse[d][p] = 1'b1;
          pstart[d][p]   = tn;
        end
        cprev[d][p] = r;
      end
      praw = praw | joy_in[d][16*p+jw+2];
    end
    exp_serv[d]  = rst | ~k[20];
    exp_pause[d] = rst | ~paused[d];
    if (rst) begin
      kf[d] = '0; tog[d] = ps2_in[d][10]; t[d] = 0;
      in_pulse[d] = '0; cprev[d] = '0; paused[d] = 1'b0; pprev[d] = 1'b0;
    end else begin
      if (praw && !pprev[d]) paused[d] = ~paused[d];
      pprev[d] = praw;
      if (ps2_in[d][10] != tog[d]) begin
        fid = key_fid(ps2_in[d][7:0]);
        if (fid >= 0) kf[d][fid] = ps2_in[d][9];
        tog[d] = ps2_in[d][10];
      end
      t[d] = tn;
    end
  endtask

  int coin_low_a, coin_low_b;

  // Predict the next edge, let it happen, compare on the falling edge.
  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check("joy_a",   32'(joy_a),   exp_joy[0]);
    check("start_a", 32'(start_a), 32'(exp_start[0][1:0]));
    check("coin_a",  32'(coin_a),  32'(exp_coin[0][1:0]));
    check("serv_a",  32'(serv_a),  32'(exp_serv[0]));
    check("pause_a", 32'(pause_a), 32'(exp_pause[0]));
    check("joy_b",   32'(joy_b),   exp_joy[1]);
    check("start_b", 32'(start_b), 32'(exp_start[1][0]));
    check("coin_b",  32'(coin_b),  32'(exp_coin[1][0]));
    check("serv_b",  32'(serv_b),  32'(exp_serv[1]));
    check("pause_b", 32'(pause_b), 32'(exp_pause[1]));
    if (!coin_a[0]) coin_low_a++;
    if (!coin_b[0]) coin_low_b++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input int d, input logic [7:0] code, input logic pressed);
    ps2_in[d] = {~ps2_in[d][10], pressed, 1'b0, code};
    tick();
  endtask

  logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29,
                             8'h12, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
                             8'h15, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h03};

  initial begin
    for (int d = 0; d < 2; d++) begin
      ps2_in[d] = '0; joy_in[d] = '0; en_in[d] = '0;
      kf[d] = '0; tog[d] = 1'b0; t[d] = 0; in_pulse[d] = '0; cprev[d] = '0;
      paused[d] = 1'b0; pprev[d] = 1'b0;
    end
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    check("reset_joy_a", 32'(joy_a), 32'h3fff);
    check("reset_pause_a", 32'(pause_a), 32'd1);

    // keyboard up: two cycles to the output, release restores it
    key(0, 8'h75, 1'b1);
    check("kbd_up_lat1", 32'(joy_a[3]), 32'd1);
    tick();
    check("kbd_up_lat2", 32'(joy_a[3]), 32'd0);
    key(0, 8'h75, 1'b0);
    ticks(2);
    check("kbd_up_rel", 32'(joy_a[3]), 32'd1);

    // keyboard and joystick on the same bit are ORed
    joy_in[0][0] = 1'b1;
    key(0, 8'h74, 1'b1);
    ticks(2);
    key(0, 8'h74, 1'b0);
    ticks(2);
    check("or_hold", 32'(joy_a[0]), 32'd0);
    joy_in[0][0] = 1'b0;
    ticks(2);

    // coin, short press: exactly COIN_W cycles
    coin_low_a = 0;
    joy_in[0][8] = 1'b1; ticks(3);
    joy_in[0][8] = 1'b0; ticks(15);
    check("coin_short", 32'(coin_low_a), 32'd8);
    // coin, long press: low until release + 1
    coin_low_a = 0;
    joy_in[0][8] = 1'b1; ticks(20);
    joy_in[0][8] = 1'b0; ticks(15);
    check("coin_long", 32'(coin_low_a), 32'd20);
    // second press during the pulse does not extend it
    coin_low_a = 0;
    joy_in[0][8] = 1'b1; ticks(2);
    joy_in[0][8] = 1'b0; ticks(2);
    joy_in[0][8] = 1'b1; ticks(2);
    joy_in[0][8] = 1'b0; ticks(20);
    check("coin_noretrig", 32'(coin_low_a), 32'd8);

    // autofire on button 0, then steady with autofire off
    en_in[0] = 6'b000001;
    joy_in[0][4] = 1'b1; ticks(17);
    en_in[0] = 6'b000000; ticks(8);
    check("af_off", 32'(joy_a[4]), 32'd0);
    joy_in[0][4] = 1'b0; ticks(2);

    // pause key toggles twice; two joystick sources together toggle once
    key(0, 8'h0C, 1'b1); ticks(3);
    check("pause_key1", 32'(pause_a), 32'd0);
    key(0, 8'h0C, 1'b0); ticks(3);
    key(0, 8'h0C, 1'b1); ticks(3);
    check("pause_key2", 32'(pause_a), 32'd1);
    key(0, 8'h0C, 1'b0); ticks(3);
    joy_in[0][9] = 1'b1; joy_in[0][25] = 1'b1; ticks(4);
    check("pause_joy2", 32'(pause_a), 32'd0);
    joy_in[0][9] = 1'b0; joy_in[0][25] = 1'b0; ticks(3);

    // reset in the middle of a coin pulse
    joy_in[0][8] = 1'b1; tick();
    joy_in[0][8] = 1'b0; ticks(3);
    rst = 1'b1; tick();
    check("coin_rst", 32'(coin_a[0]), 32'd1);
    rst = 1'b0; ticks(10);

    // single-player, single-button build: P2 and high-button keys are inert
    key(1, 8'h2D, 1'b1); key(1, 8'h2B, 1'b1); key(1, 8'h23, 1'b1);
    key(1, 8'h34, 1'b1); key(1, 8'h1C, 1'b1); key(1, 8'h12, 1'b1);
    key(1, 8'h29, 1'b1); ticks(2);
    check("b_inert", 32'(joy_b), 32'h1f);
    key(1, 8'h14, 1'b1); ticks(2);
    check("b_btn0", 32'(joy_b), 32'h0f);
    key(1, 8'h14, 1'b0); ticks(2);
    // COIN_W = 1: one-cycle pulse on immediate release
    coin_low_b = 0;
    joy_in[1][6] = 1'b1; tick();
    joy_in[1][6] = 1'b0; ticks(4);
    check("b_coin1", 32'(coin_low_b), 32'd1);
    coin_low_b = 0;
    joy_in[1][6] = 1'b1; ticks(3);
    joy_in[1][6] = 1'b0; ticks(4);
    check("b_coin3", 32'(coin_low_b), 32'd3);

    // randomized traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 5) == 0) begin
          logic [7:0] c;
          c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 19)];
          ps2_in[d] = {~ps2_in[d][10], 1'($urandom_range(0, 1)), 1'($urandom), c};
        end
        if ($urandom_range(0, 2) == 0) begin
          int p, b;
          p = $urandom_range(0, pl(d) - 1);
          b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 6 + bt(d));
          joy_in[d][16*p+b] = ~joy_in[d][16*p+b];
        end
        if ($urandom_range(0, 63) == 0) en_in[d] = 6'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
